score_keeper: RTL

Game score bookkeeping stage. It sits directly upstream of the seven-segment display driver and supplies the `score` and `hiscore` bytes that the driver splits into decimal digits. It counts points during a game, manages lives and the game-over transition, and latches the high score. All outputs are registered binary values that stay stable between events, so the display can sample them at any time.

---
 rtl/score_pkg.sv | 18 +
 rtl/score_keeper_if.sv | 21 ++
 rtl/edge_detect.sv | 23 ++
 rtl/score_keeper.sv | 138 +++++++++++++
 4 files changed

// File: rtl/score_pkg.sv
// Shared types and default constants for the score keeper.
package score_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        OVER = 2'd2
    } state_t;

    localparam int DEF_MAX_SCORE = 99;
    localparam int DEF_LIVES     = 3;

    // Saturating increment used for the score byte.
    function automatic logic [7:0] sat_inc(input logic [7:0] val, input logic [7:0] max_val);
        return (val < max_val) ? val + 8'd1 : max_val;
    endfunction

endpackage

// File: rtl/score_keeper_if.sv
// Game-logic side bundle of the score keeper: event levels in, display values out.
interface score_keeper_if;
    logic       start;
    logic       point;
    logic       miss;
    logic [7:0] score;
    logic [7:0] hiscore;
    logic [1:0] lives;
    logic       playing;
    logic       new_hi;

    modport master (
        output start, point, miss,
        input  score, hiscore, lives, playing, new_hi
    );

    modport slave (
        input  start, point, miss,
        output score, hiscore, lives, playing, new_hi
    );
endinterface

// File: rtl/edge_detect.sv
// Rising-edge detector with a registered single-cycle pulse.
// History resets to 1 so a level already high out of reset never fires.
module edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise
);

    logic hist;

    // Track the previous level and register the rise pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hist <= 1'b1;
            rise <= 1'b0;
        end else begin
            hist <= din;
            rise <= din & ~hist;
        end
    end

endmodule

// File: rtl/score_keeper.sv
// Score keeper: counts points, tracks lives, latches the high score.
// Optional lives counter is built when SCORE_KEEPER_LIVES_EN is defined;
// otherwise any miss ends the game and lives reads constant 0.
//
// state | meaning
// IDLE  | after reset, waiting for the first start
// PLAY  | game in progress, points and misses counted
// OVER  | game finished, score held for display
module score_keeper
    import score_pkg::*;
#(
    parameter int MAX_SCORE = DEF_MAX_SCORE,
    parameter int LIVES     = DEF_LIVES
) (
    input  logic           clk,
    input  logic           rst_n,
    score_keeper_if.slave  bus
);

    if (MAX_SCORE < 1 || MAX_SCORE > 255) begin : g_bad_max
        $error("score_keeper: MAX_SCORE out of range 1..255");
    end
    if (LIVES < 1 || LIVES > 3) begin : g_bad_lives
        $error("score_keeper: LIVES out of range 1..3");
    end

    localparam logic [7:0] MAX8 = 8'(MAX_SCORE);

    logic start_r, point_r, miss_r;

    edge_detect u_start (.clk(clk), .rst_n(rst_n), .din(bus.start), .rise(start_r));
    edge_detect u_point (.clk(clk), .rst_n(rst_n), .din(bus.point), .rise(point_r));
    edge_detect u_miss  (.clk(clk), .rst_n(rst_n), .din(bus.miss),  .rise(miss_r));

    state_t     state_q, state_d;
    logic [7:0] score_q, score_d;
    logic [7:0] hi_q, hi_d;
    logic       new_hi_q, new_hi_d;
    logic       playing_q;
    logic [7:0] s_next;
    logic       game_over;

`ifdef SCORE_KEEPER_LIVES_EN
    localparam logic [1:0] LIVES2 = 2'(LIVES);
    logic [1:0] lives_q, lives_d;

    // Lives counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lives_q <= LIVES2;
        end else begin
            lives_q <= lives_d;
        end
    end

    // Next lives value and whether this miss ends the game.
    always_comb begin
        lives_d   = lives_q;
        game_over = 1'b0;
        if ((state_q == IDLE || state_q == OVER) && start_r) begin
            lives_d = LIVES2;
        end else if (state_q == PLAY && miss_r) begin
            if (lives_q > 2'd1) begin
                lives_d = lives_q - 2'd1;
            end else begin
                lives_d   = 2'd0;
                game_over = 1'b1;
            end
        end
    end

    assign bus.lives = lives_q;
`else
    // Without a lives counter, every miss in play ends the game.
    always_comb begin
        game_over = (state_q == PLAY) && miss_r;
    end

    assign bus.lives = 2'd0;
`endif

    // State and score registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            score_q   <= 8'd0;
            hi_q      <= 8'd0;
            new_hi_q  <= 1'b0;
            playing_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            score_q   <= score_d;
            hi_q      <= hi_d;
            new_hi_q  <= new_hi_d;
            playing_q <= (state_d == PLAY);
        end
    end

    // Next-state, score and high-score logic. A point in the same cycle as a
    // game-ending miss is counted before the high-score comparison.
    always_comb begin
        state_d  = state_q;
        score_d  = score_q;
        hi_d     = hi_q;
        new_hi_d = new_hi_q;
        s_next   = point_r ? sat_inc(score_q, MAX8) : score_q;
        case (state_q)
            IDLE, OVER: begin
                if (start_r) begin
                    state_d  = PLAY;
                    score_d  = 8'd0;
                    new_hi_d = 1'b0;
                end
            end
            PLAY: begin
                score_d = s_next;
                if (game_over) begin
                    state_d = OVER;
                    if (s_next > hi_q) begin
                        hi_d     = s_next;
                        new_hi_d = 1'b1;
                    end else begin
                        new_hi_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.score   = score_q;
    assign bus.hiscore = hi_q;
    assign bus.playing = playing_q;
    assign bus.new_hi  = new_hi_q;

endmodule
